// File: rtl/adma_axi_mem_slv_if.sv
`default_nettype none
// =============================================================================
// adma_axi_mem_slv_if : AXI4 AR/R/AW/W/B channel bundle (DMA master <-> memory)
// Revision: 1.0
// =============================================================================
interface adma_axi_mem_slv_if #(
  parameter int MST_ID_W   = 5,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 256,
  parameter int ATX_LEN_W  = 8,
  parameter int ATX_RESP_W = 2
);
  logic [MST_ID_W-1:0]   arid;
  logic [ADDR_W-1:0]     araddr;
  logic [ATX_LEN_W-1:0]  arlen;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;

  logic [MST_ID_W-1:0]   rid;
  logic [DATA_W-1:0]     rdata;
  logic [ATX_RESP_W-1:0] rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  logic [MST_ID_W-1:0]   awid;
  logic [ADDR_W-1:0]     awaddr;
  logic [ATX_LEN_W-1:0]  awlen;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_W-1:0]     wdata;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [MST_ID_W-1:0]   bid;
  logic [ATX_RESP_W-1:0] bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output arid, araddr, arlen, arburst, arvalid, rready,
    output awid, awaddr, awlen, awburst, awvalid, wdata, wlast, wvalid, bready,
    input  arready, rid, rdata, rresp, rlast, rvalid,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  arid, araddr, arlen, arburst, arvalid, rready,
    input  awid, awaddr, awlen, awburst, awvalid, wdata, wlast, wvalid, bready,
    output arready, rid, rdata, rresp, rlast, rvalid,
    output awready, wready, bid, bresp, bvalid
  );
endinterface
`default_nettype wire

// File: rtl/adma_axi_mem_slv.sv
`default_nettype none
// =============================================================================
// adma_axi_mem_slv : AXI4 slave with word-addressed memory, one read + one write burst
// Revision: 1.0
// =============================================================================
module adma_axi_mem_slv #(
  parameter int MST_ID_W   = 5,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 256,
  parameter int ATX_LEN_W  = 8,
  parameter int ATX_RESP_W = 2,
  parameter int MEM_DEPTH  = 1024
) (
  input wire clk,
  input wire rst_n,
  adma_axi_mem_slv_if.slave s
);
  localparam int OFF_W  = $clog2(DATA_W / 8);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int WIDX_W = ADDR_W - OFF_W;
  localparam logic [WIDX_W-1:0]     DEPTH_LIM   = WIDX_W'(MEM_DEPTH);
  localparam logic [1:0]            BURST_INCR  = 2'b01;
  localparam logic [ATX_RESP_W-1:0] RESP_OKAY   = '0;
  localparam logic [ATX_RESP_W-1:0] RESP_SLVERR = ATX_RESP_W'(2);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // Word index is kept at full width so INCR bursts running past the end stay out of range.
  function automatic logic beat_bad(input logic [WIDX_W-1:0] idx, input logic [1:0] burst);
    return burst[1] || (idx >= DEPTH_LIM);
  endfunction

  // ---------------------------------------------------------------- read side
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_BURST = 1'b1} rd_state_t;

  rd_state_t             rd_state;
  logic [WIDX_W-1:0]     rd_idx;
  logic [ATX_LEN_W-1:0]  rd_len;
  logic [ATX_LEN_W-1:0]  rd_cnt;
  logic [1:0]            rd_burst;
  logic                  arready;
  logic                  rvalid;
  logic                  rlast;
  logic [MST_ID_W-1:0]   rid;
  logic [DATA_W-1:0]     rdata;
  logic [ATX_RESP_W-1:0] rresp;

  logic [WIDX_W-1:0] ar_idx;
  logic [WIDX_W-1:0] rd_idx_nxt;
  logic [WIDX_W-1:0] ld_idx;
  logic [1:0]        ld_burst;
  logic              ld_err;
  logic [DATA_W-1:0] ld_data;

  assign ar_idx     = s.araddr[ADDR_W-1:OFF_W];
  assign rd_idx_nxt = (rd_burst == BURST_INCR) ? rd_idx + WIDX_W'(1) : rd_idx;
  assign ld_idx     = (rd_state == R_IDLE) ? ar_idx : rd_idx_nxt;
  assign ld_burst   = (rd_state == R_IDLE) ? s.arburst : rd_burst;
  assign ld_err     = beat_bad(ld_idx, ld_burst);
  assign ld_data    = ld_err ? '0 : mem[ld_idx[IDX_W-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state <= R_IDLE;
      rd_idx   <= '0;
      rd_len   <= '0;
      rd_cnt   <= '0;
      rd_burst <= '0;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
      rid      <= '0;
      rdata    <= '0;
      rresp    <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (arready && s.arvalid) begin
            arready  <= 1'b0;
            rvalid   <= 1'b1;
            rid      <= s.arid;
            rd_idx   <= ar_idx;
            rd_len   <= s.arlen;
            rd_cnt   <= '0;
            rd_burst <= s.arburst;
            rlast    <= (s.arlen == '0);
            rdata    <= ld_data;
            rresp    <= ld_err ? RESP_SLVERR : RESP_OKAY;
            rd_state <= R_BURST;
          end
        end
        R_BURST: begin
          if (s.rready) begin
            if (rlast) begin
              rvalid   <= 1'b0;
              rlast    <= 1'b0;
              arready  <= 1'b1;
              rd_state <= R_IDLE;
            end else begin
              rd_idx <= rd_idx_nxt;
              rd_cnt <= rd_cnt + ATX_LEN_W'(1);
              rlast  <= (rd_cnt + ATX_LEN_W'(1) == rd_len);
              rdata  <= ld_data;
              rresp  <= ld_err ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------- write side
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_state_t;

  wr_state_t             wr_state;
  logic [WIDX_W-1:0]     wr_idx;
  logic [ATX_LEN_W-1:0]  wr_len;
  logic [ATX_LEN_W-1:0]  wr_cnt;
  logic [1:0]            wr_burst;
  logic                  wr_err;
  logic                  wr_over;
  logic                  awready;
  logic                  wready;
  logic                  bvalid;
  logic [MST_ID_W-1:0]   bid;
  logic [ATX_RESP_W-1:0] bresp;

  logic w_hs;
  logic wr_beat_err;
  logic wr_fault;
  logic mem_we;

  assign w_hs        = wready && s.wvalid;
  assign wr_beat_err = beat_bad(wr_idx, wr_burst);
  // wr_over marks beats past awlen: they are dropped and flag the burst.
  assign wr_fault    = wr_over || wr_beat_err || (s.wlast != (wr_cnt == wr_len));
  assign mem_we      = w_hs && !wr_over && !wr_beat_err;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_idx[IDX_W-1:0]] <= s.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state <= W_IDLE;
      wr_idx   <= '0;
      wr_len   <= '0;
      wr_cnt   <= '0;
      wr_burst <= '0;
      wr_err   <= 1'b0;
      wr_over  <= 1'b0;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bid      <= '0;
      bresp    <= '0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          awready <= 1'b1;
          if (awready && s.awvalid) begin
            awready  <= 1'b0;
            wready   <= 1'b1;
            bid      <= s.awid;
            wr_idx   <= s.awaddr[ADDR_W-1:OFF_W];
            wr_len   <= s.awlen;
            wr_cnt   <= '0;
            wr_burst <= s.awburst;
            wr_err   <= 1'b0;
            wr_over  <= 1'b0;
            wr_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            wr_err <= wr_err | wr_fault;
            wr_idx <= (wr_burst == BURST_INCR) ? wr_idx + WIDX_W'(1) : wr_idx;
            if (!wr_over) begin
              if (wr_cnt == wr_len) wr_over <= 1'b1;
              else                  wr_cnt  <= wr_cnt + ATX_LEN_W'(1);
            end
            if (s.wlast) begin
              wready   <= 1'b0;
              bvalid   <= 1'b1;
              bresp    <= (wr_err || wr_fault) ? RESP_SLVERR : RESP_OKAY;
              wr_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s.bready) begin
            bvalid   <= 1'b0;
            awready  <= 1'b1;
            wr_state <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  assign s.arready = arready;
  assign s.rvalid  = rvalid;
  assign s.rlast   = rlast;
  assign s.rid     = rid;
  assign s.rdata   = rdata;
  assign s.rresp   = rresp;
  assign s.awready = awready;
  assign s.wready  = wready;
  assign s.bvalid  = bvalid;
  assign s.bid     = bid;
  assign s.bresp   = bresp;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{s.araddr[OFF_W-1:0], s.awaddr[OFF_W-1:0]};

endmodule
`default_nettype wire

// File: tb/tb_adma_axi_mem_slv.sv
`default_nettype none
// =============================================================================
// tb_adma_axi_mem_slv : scoreboard bench with random stimulus and reference memory
// Revision: 1.0
// =============================================================================
module tb_adma_axi_mem_slv;
  localparam int MST_ID_W   = 5;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 256;
  localparam int ATX_LEN_W  = 8;
  localparam int ATX_RESP_W = 2;
  localparam int MEM_DEPTH  = 1024;
  localparam int BPW        = DATA_W / 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adma_axi_mem_slv_if #(
    .MST_ID_W(MST_ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .ATX_LEN_W(ATX_LEN_W), .ATX_RESP_W(ATX_RESP_W)
  ) bus ();

  adma_axi_mem_slv #(
    .MST_ID_W(MST_ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .ATX_LEN_W(ATX_LEN_W), .ATX_RESP_W(ATX_RESP_W), .MEM_DEPTH(MEM_DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .s    (bus)
  );

  typedef struct {
    logic [MST_ID_W-1:0] id;
    logic [DATA_W-1:0]   data;
    logic [1:0]          resp;
    logic                last;
  } rbeat_t;

  typedef struct {
    logic [MST_ID_W-1:0] id;
    logic [1:0]          resp;
  } bexp_t;

  rbeat_t            rq[$];
  bexp_t             bq[$];
  logic [DATA_W-1:0] model [MEM_DEPTH];
  logic [DATA_W-1:0] wbeats[$];
  int                n_cmp = 0;
  int                n_err = 0;
  int                rbeats_seen = 0;
  bit                rand_ready = 1'b0;

  task automatic check(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting for handshake (got none, required one)", name);
  endtask

  // Ready generators: always-ready for directed timing checks, random stalls otherwise.
  initial begin
    bus.rready = 1'b1;
    bus.bready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.rready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.bready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // R monitor / scoreboard
  rbeat_t r_exp;
  rbeat_t r_prev;
  bit     r_stall = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      r_stall = 1'b0;
    end else begin
      if (r_stall) begin
        check("r_hold_valid", bus.rvalid, 1'b1);
        check("r_hold_data", bus.rdata, r_prev.data);
        check("r_hold_meta", {bus.rid, bus.rresp, bus.rlast}, {r_prev.id, r_prev.resp, r_prev.last});
      end
      if (bus.rvalid && bus.rready) begin
        r_stall = 1'b0;
        rbeats_seen++;
        if (rq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL r_unexpected: got beat data %0h, required no beat", bus.rdata);
        end else begin
          r_exp = rq.pop_front();
          check("r_data", bus.rdata, r_exp.data);
          check("r_resp", bus.rresp, r_exp.resp);
          check("r_last", bus.rlast, r_exp.last);
          check("r_id", bus.rid, r_exp.id);
        end
      end else if (bus.rvalid) begin
        r_stall = 1'b1;
        r_prev  = '{bus.rid, bus.rdata, bus.rresp, bus.rlast};
      end else begin
        r_stall = 1'b0;
      end
    end
  end

  // B monitor / scoreboard
  bexp_t b_exp;
  bexp_t b_prev;
  bit    b_stall = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      b_stall = 1'b0;
    end else begin
      if (b_stall) begin
        check("b_hold_valid", bus.bvalid, 1'b1);
        check("b_hold_meta", {bus.bid, bus.bresp}, {b_prev.id, b_prev.resp});
      end
      if (bus.bvalid && bus.bready) begin
        b_stall = 1'b0;
        if (bq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL b_unexpected: got bid %0h, required no response", bus.bid);
        end else begin
          b_exp = bq.pop_front();
          check("b_resp", bus.bresp, b_exp.resp);
          check("b_id", bus.bid, b_exp.id);
        end
      end else if (bus.bvalid) begin
        b_stall = 1'b1;
        b_prev  = '{bus.bid, bus.bresp};
      end else begin
        b_stall = 1'b0;
      end
    end
  end

  // Read burst: expected beats come from the reference memory at issue time.
  task automatic do_ar(input int id, input logic [31:0] addr, input int len, input int burst, input bit timing);
    int cyc;
    int idx;
    bit err;
    for (int b = 0; b <= len; b++) begin
      idx = int'(addr / BPW) + ((burst == 1) ? b : 0);
      err = (burst >= 2) || (idx >= MEM_DEPTH);
      rq.push_back('{MST_ID_W'(id), err ? '0 : model[idx], err ? 2'b10 : 2'b00, b == len});
    end
    @(posedge clk);
    #1;
    bus.arvalid = 1'b1;
    bus.arid    = MST_ID_W'(id);
    bus.araddr  = addr;
    bus.arlen   = ATX_LEN_W'(len);
    bus.arburst = 2'(burst);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.arready && cyc < 100);
    if (!bus.arready) begin
      timeout("ar_accept");
      bus.arvalid = 1'b0;
      rq.delete();
      return;
    end
    @(posedge clk);
    #1;
    bus.arvalid = 1'b0;
    if (timing) begin
      for (int b = 0; b <= len; b++) begin
        @(negedge clk);
        check("r_valid_cycle", bus.rvalid, 1'b1);
        check("ar_ready_busy", bus.arready, 1'b0);
      end
      @(negedge clk);
      check("ar_ready_again", {bus.arready, bus.rvalid}, 2'b10);
    end else begin
      @(negedge clk);
      check("r_valid_after_ar", bus.rvalid, 1'b1);
    end
    cyc = 0;
    while (rq.size() != 0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (rq.size() != 0) begin
      timeout("r_drain");
      rq.delete();
    end
  endtask

  // Write burst of wbeats (wlast on the final entry); reference memory updated at issue time.
  task automatic do_aw(input int id, input logic [31:0] addr, input int len, input int burst, input bit stalls);
    int cyc;
    int idx;
    int n;
    bit err;
    bit berr;
    bit last;
    n   = wbeats.size();
    err = 1'b0;
    for (int b = 0; b < n; b++) begin
      idx  = int'(addr / BPW) + ((burst == 1) ? b : 0);
      berr = (burst >= 2) || (idx >= MEM_DEPTH);
      last = (b == n - 1);
      if (b > len) err = 1'b1;
      else begin
        if (berr) err = 1'b1;
        else model[idx] = wbeats[b];
        if (last != (b == len)) err = 1'b1;
      end
    end
    bq.push_back('{MST_ID_W'(id), err ? 2'b10 : 2'b00});
    @(posedge clk);
    #1;
    bus.awvalid = 1'b1;
    bus.awid    = MST_ID_W'(id);
    bus.awaddr  = addr;
    bus.awlen   = ATX_LEN_W'(len);
    bus.awburst = 2'(burst);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.awready && cyc < 100);
    if (!bus.awready) begin
      timeout("aw_accept");
      bus.awvalid = 1'b0;
      bq.delete();
      wbeats.delete();
      return;
    end
    @(posedge clk);
    #1;
    bus.awvalid = 1'b0;
    @(negedge clk);
    check("w_ready_after_aw", bus.wready, 1'b1);
    for (int b = 0; b < n; b++) begin
      @(posedge clk);
      #1;
      if (stalls) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      bus.wvalid = 1'b1;
      bus.wdata  = wbeats[b];
      bus.wlast  = (b == n - 1);
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!bus.wready && cyc < 100);
      if (!bus.wready) begin
        timeout("w_accept");
        bus.wvalid = 1'b0;
        bq.delete();
        wbeats.delete();
        return;
      end
      @(posedge clk);
      #1;
      bus.wvalid = 1'b0;
      bus.wlast  = 1'b0;
    end
    @(negedge clk);
    check("b_valid_after_wlast", bus.bvalid, 1'b1);
    if (!rand_ready) begin
      @(negedge clk);
      check("aw_ready_after_b", {bus.awready, bus.bvalid}, 2'b10);
    end
    cyc = 0;
    while (bq.size() != 0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (bq.size() != 0) begin
      timeout("b_drain");
      bq.delete();
    end
    wbeats.delete();
  endtask

  function automatic logic [DATA_W-1:0] rnd_word();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int cyc;
    bus.arvalid = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arburst = '0;
    bus.awvalid = 1'b0; bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awburst = '0;
    bus.wvalid  = 1'b0; bus.wdata = '0; bus.wlast = 1'b0;

    // Reset state and release timing
    repeat (2) @(negedge clk);
    check("rst_valids", {bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid}, 5'b0);
    check("rst_payload", {bus.rid, bus.bid, bus.rresp, bus.bresp, bus.rlast}, '0);
    check("rst_rdata", bus.rdata, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_before_sample", {bus.arready, bus.awready}, 2'b00);
    @(negedge clk);
    check("ready_after_reset", {bus.arready, bus.awready}, 2'b11);

    // Preload words 0..255 and 1016..1023
    for (int k = 0; k < 33; k++) begin
      for (int b = 0; b < 8; b++) wbeats.push_back(rnd_word());
      do_aw(k, 32'(((k == 32) ? 1016 : k * 8) * BPW), 7, 1, 1'b0);
    end

    // INCR write then read back
    for (int b = 0; b < 4; b++) wbeats.push_back(DATA_W'(32'hA0 + b));
    do_aw(5, 32'h40, 3, 1, 1'b0);
    do_ar(9, 32'h40, 3, 1, 1'b1);

    // FIXED write then FIXED read
    for (int b = 1; b <= 3; b++) wbeats.push_back(DATA_W'(b));
    do_aw(3, 32'h20, 2, 0, 1'b0);
    do_ar(4, 32'h20, 1, 0, 1'b1);

    // Range crossing and unsupported burst reads
    do_ar(1, 32'((MEM_DEPTH - 2) * BPW), 3, 1, 1'b1);
    do_ar(2, 32'h100, 2, 2, 1'b1);
    do_ar(2, 32'h100, 0, 3, 1'b1);

    // Early wlast, missing wlast (extra beat dropped), WRAP write
    for (int b = 0; b < 2; b++) wbeats.push_back(rnd_word());
    do_aw(6, 32'h3000, 3, 1, 1'b0);
    for (int b = 0; b < 3; b++) wbeats.push_back(rnd_word());
    do_aw(7, 32'h3100, 1, 1, 1'b0);
    do_ar(8, 32'h3100, 2, 1, 1'b1);
    for (int b = 0; b < 2; b++) wbeats.push_back(rnd_word());
    do_aw(10, 32'h60, 1, 2, 1'b0);
    do_ar(11, 32'h60, 1, 1, 1'b1);

    // Concurrent random traffic: reads from words 0..255 / past end, writes to 512..767
    rand_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          int sel;
          int len;
          sel = $urandom_range(0, 9);
          len = $urandom_range(0, 7);
          if (sel < 7)
            do_ar($urandom_range(0, 31), 32'($urandom_range(0, 248) * BPW + $urandom_range(0, BPW - 1)), len, $urandom_range(0, 1), 1'b0);
          else if (sel < 9)
            do_ar($urandom_range(0, 31), 32'($urandom_range(1020, 1030) * BPW), len, 1, 1'b0);
          else
            do_ar($urandom_range(0, 31), 32'($urandom_range(0, 248) * BPW), len, $urandom_range(2, 3), 1'b0);
        end
      end
      begin
        for (int i = 0; i < 16; i++) begin
          int len;
          len = $urandom_range(0, 7);
          for (int b = 0; b <= len; b++) wbeats.push_back(rnd_word());
          do_aw($urandom_range(0, 31), 32'($urandom_range(512, 760) * BPW + $urandom_range(0, BPW - 1)), len,
                ($urandom_range(0, 7) == 0) ? 2 : $urandom_range(0, 1), 1'b1);
        end
      end
    join
    rand_ready = 1'b0;
    for (int k = 0; k < 32; k++) do_ar(k, 32'((512 + k * 8) * BPW), 7, 1, 1'b0);

    // Reset in the middle of an 8-beat read
    base = rbeats_seen;
    for (int b = 0; b < 8; b++) rq.push_back('{MST_ID_W'(12), model[16 + b], 2'b00, b == 7});
    @(posedge clk);
    #1;
    bus.arvalid = 1'b1; bus.arid = 12; bus.araddr = 32'(16 * BPW); bus.arlen = 7; bus.arburst = 2'b01;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.arready && cyc < 100);
    @(posedge clk);
    #1;
    bus.arvalid = 1'b0;
    cyc = 0;
    while (rbeats_seen < base + 2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (rbeats_seen < base + 2) timeout("reset_burst_beats");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rvalid_in_reset", {bus.rvalid, bus.rlast, bus.arready}, 3'b000);
    rq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ar_ready_release", bus.arready, 1'b0);
    @(negedge clk);
    check("ar_ready_post_reset", {bus.arready, bus.awready, bus.rvalid}, 3'b110);
    do_ar(13, 32'(16 * BPW), 7, 1, 1'b1);
    do_ar(14, 32'h40, 3, 1, 1'b1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
